// File: rtl/program_loader.sv
// Boot loader: takes a framed byte stream (length, payload, XOR checksum), buffers it
// in a small FIFO and writes the payload into program RAM while holding the CPU in reset.
module program_loader #(
    parameter int ADDR_W     = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              ram_grant,
    output logic [7:0]        ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   byte_count
);

    localparam int                PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                CAP     = (1 << ADDR_W) - BASE_ADDR;
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [PTR_W:0]    DEPTH   = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]    CNT_ONE = (PTR_W+1)'(1);
    localparam logic [ADDR_W:0]   BC_ONE  = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t state_reg, state_next;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             fifo_full, fifo_empty;
    logic             active, push, pop, flush;
    logic [7:0]       pop_data;

    logic [ADDR_W:0]   length_reg;
    logic [ADDR_W:0]   byte_count_reg;
    logic [7:0]        checksum_reg;
    logic              ram_we_reg;
    logic [7:0]        ram_data_reg;
    logic [ADDR_W-1:0] ram_addr_reg;

    logic header_bad, last_payload;

    assign fifo_full  = (count_reg == DEPTH);
    assign fifo_empty = (count_reg == '0);
    assign push       = in_valid && in_ready;
    assign flush      = restart && (state_reg == S_DONE || state_reg == S_ERR);
    assign pop_data   = fifo_mem[rd_ptr_reg];

    assign header_bad   = (pop_data == 8'd0) || (int'(pop_data) > CAP);
    assign last_payload = ((byte_count_reg + BC_ONE) == length_reg);

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + CNT_ONE;
            end else if (pop && !push) begin
                count_reg <= count_reg - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (pop) state_next = header_bad ? S_ERR : S_LOAD;
            S_LOAD:  if (pop && last_payload) state_next = S_CHECK;
            S_CHECK: if (pop) state_next = (pop_data == checksum_reg) ? S_DONE : S_ERR;
            S_DONE:  if (restart) state_next = S_IDLE;
            S_ERR:   if (restart) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        active   = (state_reg == S_IDLE) || (state_reg == S_LOAD) || (state_reg == S_CHECK);
        in_ready = active && !fifo_full;
        pop      = active && !fifo_empty && ram_grant;
        done     = (state_reg == S_DONE);
        error    = (state_reg == S_ERR);
        cpu_hold = (state_reg != S_DONE);
    end

    // Payload datapath: only LOAD-state pops reach the RAM port; header and checksum bytes never do.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            length_reg     <= '0;
            byte_count_reg <= '0;
            checksum_reg   <= '0;
            ram_we_reg     <= 1'b0;
            ram_data_reg   <= '0;
            ram_addr_reg   <= BASE;
        end else begin
            ram_we_reg <= 1'b0;
            if (flush) begin
                byte_count_reg <= '0;
                checksum_reg   <= '0;
                ram_addr_reg   <= BASE;
            end else if (pop) begin
                case (state_reg)
                    S_IDLE: begin
                        length_reg     <= (ADDR_W+1)'(pop_data);
                        byte_count_reg <= '0;
                        checksum_reg   <= '0;
                    end
                    S_LOAD: begin
                        ram_we_reg     <= 1'b1;
                        ram_data_reg   <= pop_data;
                        ram_addr_reg   <= BASE + byte_count_reg[ADDR_W-1:0];
                        checksum_reg   <= checksum_reg ^ pop_data;
                        byte_count_reg <= byte_count_reg + BC_ONE;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign ram_we     = ram_we_reg;
    assign ram_data   = ram_data_reg;
    assign ram_addr   = ram_addr_reg;
    assign byte_count = byte_count_reg;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream boot loader that fills the CPU's program RAM before execution starts.
- Accepts a framed byte stream over a valid/ready handshake (length header, payload, XOR checksum) and buffers it in a small FIFO. It then drives the RAM write port (Data_w / ram_we / address) one byte per granted cycle.
- Holds the CPU in reset via cpu_hold until a frame loads with a good checksum.
- Sits directly upstream of the CPU's RAM write port.

Parameters:
- ADDR_W, 6: RAM address width, matching the 6-bit PC.
- FIFO_DEPTH, 4: input byte FIFO entries; power of 2, minimum 2.
- BASE_ADDR, 0: RAM address of the first payload byte.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- restart  in  1  one-cycle request to return to IDLE; honoured only in DONE or ERR.
- in_valid  in  1  in_data holds a byte.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts the byte this cycle.
- ram_grant  in  1  RAM write port available; FIFO pops only when 1.
- ram_data  out  8  write data, to CPU Data_w.
- ram_addr  out  ADDR_W  write address.
- ram_we  out  1  write strobe, to CPU ram_we.
- cpu_hold  out  1  keeps the CPU in reset; OR'd into CPU rst.
- done  out  1  frame loaded, checksum good.
- error  out  1  frame rejected.
- byte_count  out  ADDR_W+1  payload bytes written so far.

Behaviour:
- Reset (async) values:
  - FSM = IDLE; FIFO empty.
  - in_ready=1, ram_we=0, ram_data=0, ram_addr=BASE_ADDR.
  - cpu_hold=1, done=0, error=0, byte_count=0.
  - Length register and checksum accumulator cleared.
- Handshake:
  - A byte is pushed when in_valid && in_ready at a rising edge.
  - in_ready = !fifo_full && state in {IDLE, LOAD, CHECK}.
  - No push-through when full, even if a pop happens in the same cycle.
  - in_data is ignored when in_ready=0.
- Pop: occurs when FIFO non-empty && ram_grant && state in {IDLE, LOAD, CHECK}. At most one pop per cycle. Simultaneous push and pop is legal; occupancy is unchanged.
- Capacity: CAP = 2^ADDR_W - BASE_ADDR (64 by default).
- FSM:
  - IDLE: a pop stores length L.
    - L==0 or L>CAP -> ERR.
    - Otherwise -> LOAD, with checksum=0 and byte_count=0.
  - LOAD: each pop registers a RAM write, visible the next cycle:
    - ram_we=1, ram_data=byte, ram_addr=BASE_ADDR+byte_count.
    - checksum ^= byte; byte_count++.
    - The pop that brings byte_count to L -> CHECK.
  - CHECK: a pop compares the byte with checksum. Equal -> DONE; else -> ERR.
  - DONE: done=1, cpu_hold=0, in_ready=0, no pops.
  - ERR: error=1, cpu_hold=1, in_ready=0, no pops.
  - restart in DONE/ERR -> IDLE in one cycle:
    - FIFO flushed; done, error and byte_count cleared.
    - cpu_hold=1; ram_addr=BASE_ADDR.
  - restart in IDLE, LOAD or CHECK is ignored.
- ram_we:
  - A registered one-cycle pulse per payload byte; never high for header or checksum bytes.
  - ram_data and ram_addr hold their last value when ram_we=0.
- Latency: with ram_grant=1 and an empty FIFO, a payload byte accepted at edge E pops at edge E+1. ram_we is high between edges E+1 and E+2, and the RAM captures it at E+2.
- byte_count saturates at L. ram_addr never wraps, because the CAP check rejects oversize frames.
- Header and checksum bytes are not included in the checksum.
- ram_grant low stalls popping; the FIFO fills and in_ready drops when full; no bytes are lost.
- rst mid-operation aborts the load immediately. Partially written RAM content is left as is.

Test Plan:
- Reset: assert rst mid-stream -> in_ready=1, cpu_hold=1, ram_we=0, done=0, error=0, byte_count=0.
- Good frame, ram_grant=1: stream 0x03, 0xA1, 0xB2, 0xC3, 0xD0 back-to-back ->
  - three ram_we pulses, at addr 0/1/2 with data A1/B2/C3;
  - then done=1, cpu_hold=0, in_ready=0, byte_count=3.
- Bad checksum: same frame with last byte 0x00 -> three writes, then error=1, cpu_hold=1, done=0.
- Header limits:
  - 0x00 -> error=1 with no ram_we.
  - After restart, 0x41 (65) -> error=1 with no ram_we.
  - After restart, 0x40 with 64 bytes and correct checksum -> done, last write at addr 63.
- Backpressure: hold ram_grant=0 and stream the good frame ->
  - exactly FIFO_DEPTH(4) bytes accepted, then in_ready=0;
  - release ram_grant -> frame completes, done=1, same writes as the good-frame test.
- Restart: in DONE pulse restart -> IDLE next cycle, cpu_hold=1, in_ready=1; a second frame loads correctly. Pulsing restart in LOAD has no effect.
